// File: rtl/button_encoder.sv
// Button input stage for the Simon core: 2-flop sync, per-bit debounce, press encoder FSM.
// Optional chord error pulse output enabled by defining BTN_CHORD_ERR_EN.
module button_encoder #(
  parameter int DEBOUNCE_CYCLES = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] btn,
  input  logic       enable,
  output logic [1:0] playerNum,
  output logic       playerPressed,
  output logic       busy
`ifdef BTN_CHORD_ERR_EN
  ,
  output logic       chordErr
`endif
);

  localparam int CNT_W = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {IDLE, HELD} state_t;

  logic [3:0] s1_q, s2_q;
  logic [3:0] deb_q, deb_d;
  logic [3:0] deb_prev_q;
  logic [3:0] rise;
  logic [2:0] rise_cnt, deb_cnt;

  state_t     state_q;
  logic [1:0] player_num_q;
  logic       pressed_q;
  logic       busy_q;

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

  function automatic logic [1:0] onehot_index(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (v[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q       <= '0;
      s2_q       <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
    end else begin
      s1_q       <= btn;
      s2_q       <= s1_q;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
    end
  end

  // Each bit only flips after DEBOUNCE_CYCLES consecutive synced samples disagree with it.
  for (genvar gi = 0; gi < 4; gi++) begin : g_debounce
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             differ;

    assign differ = (s2_q[gi] != deb_q[gi]);

    always_comb begin
      cnt_d = cnt_q;
      if (!differ) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    assign deb_d[gi] = (differ && cnt_q == CNT_LAST) ? s2_q[gi] : deb_q[gi];

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end
  end

  assign rise     = deb_q & ~deb_prev_q;
  assign rise_cnt = popcount4(rise);
  assign deb_cnt  = popcount4(deb_q);

`ifdef BTN_CHORD_ERR_EN
  logic chord_err_q;
  assign chordErr = chord_err_q;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      player_num_q <= 2'd0;
      pressed_q    <= 1'b0;
      busy_q       <= 1'b0;
`ifdef BTN_CHORD_ERR_EN
      chord_err_q  <= 1'b0;
`endif
    end else begin
      pressed_q   <= 1'b0;
`ifdef BTN_CHORD_ERR_EN
      chord_err_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (rise != 4'b0000) begin
            state_q <= HELD;
            busy_q  <= 1'b1;
            if (enable && rise_cnt == 3'd1 && deb_cnt == 3'd1) begin
              pressed_q    <= 1'b1;
              player_num_q <= onehot_index(rise);
            end
`ifdef BTN_CHORD_ERR_EN
            // With enable high, the only way a rise is rejected is a multi-button chord.
            else if (enable) begin
              chord_err_q <= 1'b1;
            end
`endif
          end else if (deb_q != 4'b0000) begin
            state_q <= HELD;
            busy_q  <= 1'b1;
          end
        end
        HELD: begin
          if (deb_q == 4'b0000) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign playerNum     = player_num_q;
  assign playerPressed = pressed_q;
  assign busy          = busy_q;

`ifndef SYNTHESIS
  a_single_strobe: assert property (@(posedge clk) disable iff (!reset)
    playerPressed |=> !playerPressed);
`endif

endmodule

// File: tb/tb_button_encoder.sv
// Self-checking bench for button_encoder: vector table, directed corner sequences, random vs reference model.
module tb_button_encoder;

  localparam int D = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] btn;
  logic       enable;
  logic [1:0] playerNum;
  logic       playerPressed;
  logic       busy;
`ifdef BTN_CHORD_ERR_EN
  logic       chordErr;
`endif

  button_encoder #(.DEBOUNCE_CYCLES(D)) dut (
    .clk          (clk),
    .reset        (reset),
    .btn          (btn),
    .enable       (enable),
    .playerNum    (playerNum),
    .playerPressed(playerPressed),
    .busy         (busy)
`ifdef BTN_CHORD_ERR_EN
    ,
    .chordErr     (chordErr)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int strobes_seen = 0;
  int chords_seen  = 0;

  // Reference model: raw delay line, window of the last D synced samples, press tracker.
  logic [3:0] m_sync0, m_sync1;
  logic [3:0] m_hist[$];
  logic [3:0] m_deb, m_prev;
  bit         m_held, m_pressed, m_chord;
  logic [1:0] m_num;

  typedef struct packed {
    logic [3:0] btn;
    logic       en;
    logic       pressed;
    logic       busy;
    logic [1:0] num;
  } vec_t;
  vec_t vecs[18];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic model_reset();
    m_sync0 = '0; m_sync1 = '0;
    m_hist.delete();
    for (int k = 0; k < D; k++) m_hist.push_back(4'b0000);
    m_deb = '0; m_prev = '0;
    m_held = 0; m_pressed = 0; m_chord = 0; m_num = 2'd0;
  endtask

  task automatic model_step(input logic [3:0] b, input logic e);
    logic [3:0] deb_old, rise, s2_old;
    deb_old = m_deb;
    s2_old  = m_sync1;
    rise    = m_deb & ~m_prev;
    m_pressed = 0;
    m_chord   = 0;
    if (!m_held) begin
      if (rise != 0) begin
        m_held = 1;
        if (e && $countones(rise) == 1 && $countones(deb_old) == 1) begin
          m_pressed = 1;
          for (int k = 0; k < 4; k++) if (rise[k]) m_num = 2'(k);
        end else if (e) begin
          m_chord = 1;
        end
      end else if (deb_old != 0) begin
        m_held = 1;
      end
    end else if (deb_old == 0) begin
      m_held = 0;
    end
    m_prev = deb_old;
    m_hist.push_back(s2_old);
    void'(m_hist.pop_front());
    for (int bi = 0; bi < 4; bi++) begin
      bit all_diff;
      all_diff = 1;
      foreach (m_hist[k]) if (m_hist[k][bi] == deb_old[bi]) all_diff = 0;
      if (all_diff) m_deb[bi] = ~deb_old[bi];
    end
    m_sync1 = m_sync0;
    m_sync0 = b;
  endtask

  task automatic compare_model();
    check("model_pressed", 8'(playerPressed), 8'(m_pressed));
    check("model_num", 8'(playerNum), 8'(m_num));
    check("model_busy", 8'(busy), 8'(m_held));
`ifdef BTN_CHORD_ERR_EN
    check("model_chord", 8'(chordErr), 8'(m_chord));
`endif
  endtask

  task automatic tick();
    logic [3:0] b;
    logic       e;
    b = btn;
    e = enable;
    @(posedge clk);
    if (!reset) model_reset();
    else model_step(b, e);
    #1;
    if (playerPressed) strobes_seen++;
`ifdef BTN_CHORD_ERR_EN
    if (chordErr) chords_seen++;
`endif
    compare_model();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_reset();
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check("rst_num", 8'(playerNum), 8'd0);
    check("rst_pressed", 8'(playerPressed), 8'd0);
    check("rst_busy", 8'(busy), 8'd0);
    tick();
    tick();
    #2;
    reset = 1'b1;
  endtask

  initial begin
    int hold;
    int first;
    reset  = 1'b0;
    btn    = 4'b0000;
    enable = 1'b0;
    model_reset();
    #1;
    check("reset_num", 8'(playerNum), 8'd0);
    check("reset_pressed", 8'(playerPressed), 8'd0);
    check("reset_busy", 8'(busy), 8'd0);
    ticks(2);
    #2;
    reset = 1'b1;

    // Clean press of btn[2] for 10 cycles then release; entry i is sampled after edge i+1.
    for (int i = 0; i < 18; i++) begin
      vecs[i].btn     = (i < 10) ? 4'b0100 : 4'b0000;
      vecs[i].en      = 1'b1;
      vecs[i].pressed = (i == 5);
      vecs[i].busy    = (i >= 5 && i <= 14);
      vecs[i].num     = (i >= 5) ? 2'd2 : 2'd0;
    end
    for (int i = 0; i < 18; i++) begin
      btn    = vecs[i].btn;
      enable = vecs[i].en;
      tick();
      check($sformatf("vec%0d_pressed", i), 8'(playerPressed), 8'(vecs[i].pressed));
      check($sformatf("vec%0d_busy", i), 8'(busy), 8'(vecs[i].busy));
      check($sformatf("vec%0d_num", i), 8'(playerNum), 8'(vecs[i].num));
    end

    // Bounce on btn[1]: 1,0,1,0 then stable 1; strobe 6 edges after the stable 1 is applied.
    strobes_seen = 0;
    btn = 4'b0010; tick();
    btn = 4'b0000; tick();
    btn = 4'b0010; tick();
    btn = 4'b0000; tick();
    btn = 4'b0010;
    first = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (playerPressed && first == 0) first = i;
    end
    check("bounce_latency", 8'(first), 8'd6);
    check("bounce_strobes", 8'(strobes_seen), 8'd1);
    check("bounce_num", 8'(playerNum), 8'd1);
    btn = 4'b0000; ticks(10);

    // Short glitch on btn[3]: never reaches the debounced level.
    strobes_seen = 0;
    btn = 4'b1000; ticks(2);
    btn = 4'b0000; ticks(12);
    check("glitch_strobes", 8'(strobes_seen), 8'd0);
    check("glitch_num", 8'(playerNum), 8'd1);
    check("glitch_busy", 8'(busy), 8'd0);

    // Chord btn[0]+btn[3]: rejected, held until both released.
    strobes_seen = 0;
    chords_seen  = 0;
    btn = 4'b1001; ticks(12);
    check("chord_strobes", 8'(strobes_seen), 8'd0);
    check("chord_busy", 8'(busy), 8'd1);
    btn = 4'b1000; ticks(10);
    check("chord_half_busy", 8'(busy), 8'd1);
    btn = 4'b0000; ticks(10);
    check("chord_release_busy", 8'(busy), 8'd0);
`ifdef BTN_CHORD_ERR_EN
    check("chord_err_count", 8'(chords_seen), 8'd1);
`endif

    // Enable gating: held while disabled, enable raised mid-hold gives no strobe.
    strobes_seen = 0;
    enable = 1'b0;
    btn = 4'b0010; ticks(10);
    enable = 1'b1; ticks(10);
    check("gate_strobes", 8'(strobes_seen), 8'd0);
    check("gate_busy", 8'(busy), 8'd1);
    btn = 4'b0000; ticks(10);
    btn = 4'b0010; ticks(10);
    check("gate_repress_strobes", 8'(strobes_seen), 8'd1);
    check("gate_repress_num", 8'(playerNum), 8'd1);
    btn = 4'b0000; ticks(10);

    // Reset mid-debounce of btn[2]: partial count lost, strobe 6 edges after release.
    btn = 4'b0100; ticks(3);
    pulse_reset();
    first = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (playerPressed && first == 0) first = i;
    end
    check("reset_latency", 8'(first), 8'd6);
    check("reset_num_after", 8'(playerNum), 8'd2);
    btn = 4'b0000; ticks(10);

    // Random stimulus against the reference model.
    hold = 0;
    for (int r = 0; r < 3000; r++) begin
      if (hold == 0) begin
        case ($urandom_range(0, 5))
          0, 1:    btn = 4'b0000;
          2, 3:    btn = 4'(1 << $urandom_range(0, 3));
          4:       btn = 4'($urandom_range(0, 15));
          default: btn = btn ^ 4'(1 << $urandom_range(0, 3));
        endcase
        hold = int'($urandom_range(1, 10));
        if ($urandom_range(0, 7) == 0) enable = ~enable;
      end
      hold--;
      if (r == 1500) pulse_reset();
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
